// File: rtl/stft_mag_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stft_mag_sequencer_pkg
//  Description : Shared constants and helper functions for the magnitude
//                stages: clog2, saturating abs, saturating shift-truncate.
//  Revision    : 1.0 - initial release
// ============================================================================
package stft_mag_sequencer_pkg;

    localparam int c_IW_DEF = 16;
    localparam int c_OL_DEF = 10;

    // Smallest r with 2^r >= n (n >= 2 gives r >= 1)
    function automatic int f_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Absolute value of a w-bit two's complement number (sign-extended to 32
    // bits); the most negative code folds onto the largest positive one.
    function automatic logic [31:0] f_sat_abs(input logic signed [31:0] v, input int w);
        logic signed [31:0] lo;
        lo = -(32'sd1 <<< (w - 1));
        if (v == lo)
            return (32'd1 << (w - 1)) - 32'd1;
        else if (v < 0)
            return $unsigned(-v);
        else
            return $unsigned(v);
    endfunction

    // Logical right shift by sh, then clamp to the largest ol-bit code
    function automatic logic [31:0] f_sat_shift(input logic [31:0] v, input int sh, input int ol);
        logic [31:0] t;
        logic [31:0] mx;
        t  = v >> sh;
        mx = (32'd1 << ol) - 32'd1;
        return (t > mx) ? mx : t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stft_mag_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : stft_mag_sequencer_if
//  Description : Sample input and accumulator-control output bundle of the
//                STFT magnitude sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stft_mag_sequencer_if #(
    parameter int IW = 16,
    parameter int OL = 10,
    parameter int GW = 5
);
    logic                 iVALID;
    logic signed [IW-1:0] iRE;
    logic signed [IW-1:0] iIM;
    logic                 iSOF;
    logic [OL-1:0]        oDATA;
    logic                 oCLR;
    logic                 oEN;
    logic [3:0]           oCNT;
    logic [GW-1:0]        oGRP;
    logic                 oFRAME_DONE;
    logic                 oSYNC_ERR;

    modport master (
        output iVALID, iRE, iIM, iSOF,
        input  oDATA, oCLR, oEN, oCNT, oGRP, oFRAME_DONE, oSYNC_ERR
    );

    modport slave (
        input  iVALID, iRE, iIM, iSOF,
        output oDATA, oCLR, oEN, oCNT, oGRP, oFRAME_DONE, oSYNC_ERR
    );
endinterface
`default_nettype wire

// File: rtl/stft_mag_sequencer_l1.sv
`default_nettype none
// ============================================================================
//  Module      : stft_mag_l1
//  Description : Two-stage L1 magnitude datapath: |re|,|im| then sum, shift
//                and saturate, with a matching valid pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module stft_mag_l1
    import stft_mag_sequencer_pkg::*;
#(
    parameter int IW    = c_IW_DEF,
    parameter int OL    = c_OL_DEF,
    parameter int SHIFT = 7
) (
    input  wire logic                 i_clk,
    input  wire logic                 i_rst,
    input  wire logic                 i_valid,
    input  wire logic signed [IW-1:0] i_re,
    input  wire logic signed [IW-1:0] i_im,
    output logic                      o_valid,
    output logic [OL-1:0]             o_data
);

    logic [IW-2:0] w_abs_re;
    logic [IW-2:0] w_abs_im;
    logic [IW-1:0] w_sum;
    logic [OL-1:0] w_scaled;

    logic [IW-2:0] r_abs_re;
    logic [IW-2:0] r_abs_im;
    logic          r_v1;
    logic [OL-1:0] r_data;
    logic          r_v2;

    assign w_abs_re = (IW-1)'(f_sat_abs(32'(i_re), IW));
    assign w_abs_im = (IW-1)'(f_sat_abs(32'(i_im), IW));
    // Two (IW-1)-bit magnitudes always fit in IW bits
    assign w_sum    = {1'b0, r_abs_re} + {1'b0, r_abs_im};
    assign w_scaled = OL'(f_sat_shift(32'(w_sum), SHIFT, OL));

    // Stage 1: register the saturated magnitudes of both components
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_abs_re <= '0;
            r_abs_im <= '0;
            r_v1     <= 1'b0;
        end else begin
            r_abs_re <= w_abs_re;
            r_abs_im <= w_abs_im;
            r_v1     <= i_valid;
        end
    end

    // Stage 2: register the scaled and clamped sum
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= '0;
            r_v2   <= 1'b0;
        end else begin
            r_data <= w_scaled;
            r_v2   <= r_v1;
        end
    end

    assign o_valid = r_v2;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/stft_mag_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : stft_mag_sequencer
//  Description : L1 magnitude stage with accumulator control generation:
//                sample/group counting, frame-done and resync error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module stft_mag_sequencer
    import stft_mag_sequencer_pkg::*;
#(
    parameter int IW     = c_IW_DEF,
    parameter int OL     = c_OL_DEF,
    parameter int END    = 9,
    parameter int GROUPS = 32,
    parameter int SHIFT  = 7
) (
    input  wire logic           iCLK,
    input  wire logic           iRST,
    stft_mag_sequencer_if.slave bus
);

    localparam int              c_GW       = f_clog2(GROUPS);
    localparam logic [c_GW-1:0] c_GRP_LAST = c_GW'(GROUPS - 1);
    localparam logic [3:0]      c_CNT_LAST = 4'(END);

    logic            w_l1_valid;
    logic [OL-1:0]   w_l1_data;

    logic [3:0]      r_cnt;
    logic [c_GW-1:0] r_grp;
    logic            w_at_origin;
    logic [3:0]      w_smp_cnt;
    logic [c_GW-1:0] w_smp_grp;
    logic            w_smp_err;
    logic            w_last;
    logic [3:0]      w_nxt_cnt;
    logic [c_GW-1:0] w_nxt_grp;

    logic            r_sv1;
    logic [3:0]      r_cnt1;
    logic [c_GW-1:0] r_grp1;
    logic            r_err1;
    logic [3:0]      r_cnt2;
    logic [c_GW-1:0] r_grp2;
    logic            r_err2;

    stft_mag_l1 #(
        .IW    (IW),
        .OL    (OL),
        .SHIFT (SHIFT)
    ) u_l1 (
        .i_clk   (iCLK),
        .i_rst   (iRST),
        .i_valid (bus.iVALID),
        .i_re    (bus.iRE),
        .i_im    (bus.iIM),
        .o_valid (w_l1_valid),
        .o_data  (w_l1_data)
    );

    // Position of the incoming sample; SOF forces the origin and flags a
    // resync whenever the counters were not already sitting there.
    assign w_at_origin = (r_cnt == 4'd0) && (r_grp == '0);
    assign w_smp_cnt   = bus.iSOF ? 4'd0 : r_cnt;
    assign w_smp_grp   = bus.iSOF ? '0   : r_grp;
    assign w_smp_err   = bus.iSOF && !w_at_origin;
    assign w_last      = (w_smp_cnt == c_CNT_LAST);
    assign w_nxt_cnt   = w_last ? 4'd0 : w_smp_cnt + 4'd1;
    assign w_nxt_grp   = !w_last                  ? w_smp_grp :
                         (w_smp_grp == c_GRP_LAST) ? '0        :
                                                     w_smp_grp + c_GW'(1);

    // Sample/group counters advance only on accepted input samples
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_cnt <= 4'd0;
            r_grp <= '0;
        end else if (bus.iVALID) begin
            r_cnt <= w_nxt_cnt;
            r_grp <= w_nxt_grp;
        end
    end

    // Side-band delay, stage 1: capture the sample's position with its data
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_sv1  <= 1'b0;
            r_cnt1 <= 4'd0;
            r_grp1 <= '0;
            r_err1 <= 1'b0;
        end else begin
            r_sv1 <= bus.iVALID;
            if (bus.iVALID) begin
                r_cnt1 <= w_smp_cnt;
                r_grp1 <= w_smp_grp;
                r_err1 <= w_smp_err;
            end
        end
    end

    // Side-band delay, stage 2: loads only on valid so the group index holds
    // across bubbles
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_cnt2 <= 4'd0;
            r_grp2 <= '0;
            r_err2 <= 1'b0;
        end else if (r_sv1) begin
            r_cnt2 <= r_cnt1;
            r_grp2 <= r_grp1;
            r_err2 <= r_err1;
        end
    end

    // Accumulator control decode; idle cycles present count 0 and no strobes
    always_comb begin
        bus.oDATA       = w_l1_data;
        bus.oGRP        = r_grp2;
        bus.oCLR        = 1'b0;
        bus.oEN         = 1'b0;
        bus.oCNT        = 4'd0;
        bus.oFRAME_DONE = 1'b0;
        bus.oSYNC_ERR   = 1'b0;
        if (w_l1_valid) begin
            bus.oCLR        = (r_cnt2 == 4'd0);
            bus.oEN         = (r_cnt2 != 4'd0);
            bus.oCNT        = r_cnt2;
            bus.oFRAME_DONE = (r_cnt2 == c_CNT_LAST) && (r_grp2 == c_GRP_LAST) && !r_err2;
            bus.oSYNC_ERR   = r_err2;
        end
    end

endmodule
`default_nettype wire

// File: doc/stft_mag_sequencer.md
Name: stft_mag_sequencer

Overview:
Streaming stage directly upstream of the bin accumulator in the STFT feature path. Takes complex FFT bin samples (re/im) with a valid strobe and computes a pipelined L1 magnitude, |re|+|im|, scaled and saturated to the accumulator input width. It also generates the accumulator control: the clear, enable and 4-bit count that group END+1 consecutive samples into one accumulated output. It tracks groups per frame and flags frame completion and resync errors.

Parameters:
IW, 16, signed width of iRE/iIM
OL, 10, width of oDATA (equals accumulator input width)
END, 9, last count value of a group (group = END+1 samples); legal range 1..15
GROUPS, 32, groups per frame; legal range 2..1024
SHIFT, 7, right shift applied to |re|+|im| before saturation

Ports:
iCLK  in  1  clock
iRST  in  1  synchronous reset, active-high
iVALID  in  1  input sample valid
iRE  in  IW  real part, two's complement
iIM  in  IW  imaginary part, two's complement
iSOF  in  1  start of frame; qualified by iVALID
oDATA  out  OL  scaled magnitude, unsigned
oCLR  out  1  first sample of group (accumulator load)
oEN  out  1  non-first sample of group (accumulator add)
oCNT  out  4  index of presented sample within group
oGRP  out  clog2(GROUPS)  group index of presented sample
oFRAME_DONE  out  1  one-cycle pulse with last sample of frame
oSYNC_ERR  out  1  one-cycle pulse: iSOF arrived mid-frame

Behaviour:
- Reset: on iCLK edge with iRST=1, all outputs go to 0, pipeline valids clear, sample/group counters go to 0. A reset mid-frame discards in-flight samples with no partial outputs.
- Pipeline, 2 cycles fixed latency from iVALID to output strobe:
  - S1 registers |iRE| and |iIM|. abs(-2^(IW-1)) saturates to 2^(IW-1)-1. Result is IW-1 bits unsigned.
  - S2 registers the sum (IW bits, no overflow), shifted right by SHIFT (truncate), then saturated to 2^OL-1.
- No backpressure. Every valid input produces exactly one output cycle. Bubbles propagate unchanged.
- Counters advance only on input-side iVALID. Sample count and group index are captured alongside the data and travel through the pipe with it.
- Output cycle (delayed valid=1):
  - oCLR=1 iff count==0; oEN=1 iff count in 1..END.
  - oCNT=count, oGRP=group.
  - oFRAME_DONE=1 iff count==END and group==GROUPS-1.
- Idle output cycle (delayed valid=0): oCLR=oEN=oFRAME_DONE=0, oCNT=0, oGRP holds. oCNT=0 when idle ensures the accumulator's END compare cannot fire spuriously (hence END≥1).
- Count wrap: END→0 with group+1. Group wrap: GROUPS-1→0 at end of a group.
- iSOF with iVALID: the sample is forced to count 0, group 0.
  - If the counters were not already at count 0, group 0, oSYNC_ERR pulses, aligned with that sample's output cycle. The partial group is abandoned, so no oFRAME_DONE is issued for the broken frame.
  - iSOF on the sample that would naturally be count 0, group 0: no error.
  - iSOF without iVALID is ignored.
- iSOF on the would-be last sample of a frame: treated as count 0 of a new frame. No oFRAME_DONE, oSYNC_ERR=1.

Decomposition:
- Shared package: IW/OL defaults; clog2 helper for oGRP width; saturating abs and saturating shift-truncate functions, shared with other magnitude stages.
- One natural sub-module: stft_mag_l1, the 2-stage abs/sum/scale/saturate datapath with valid pipe. The sequencer keeps counters, the SOF/error logic and the side-band delay.

Test Plan:
- Reset then iVALID each cycle with re=1000, im=-500: 2 cycles later oDATA=11, oCLR=1, oCNT=0; the next 9 outputs have oEN=1, oCNT=1..9; the 11th output is oCLR=1, oGRP=1.
- re=-32768, im=-32768 with SHIFT=5 override: oDATA=1023 (saturated). With default SHIFT=7: oDATA=511.
- 320 consecutive valid samples (END=9, GROUPS=32): oFRAME_DONE pulses exactly once, with oCNT=9, oGRP=31. The next output is oCLR=1, oGRP=0, with no oSYNC_ERR.
- Valid pattern 1,0,0,1,1,0: outputs follow 2 cycles later with identical gaps. Idle cycles show oCNT=0, oCLR=oEN=0. Counts go 0,1,2 across the gaps.
- iSOF with the 5th sample of group 3: that output shows oCLR=1, oCNT=0, oGRP=0, oSYNC_ERR=1. iSOF on the very first sample after reset: oSYNC_ERR=0.
- iRST asserted for 1 cycle while two samples are in flight: no output strobes follow. The next valid yields oCNT=0, oGRP=0.
